// File: rtl/tcdm_xbar_pipe.sv
// Full crossbar from NumIn initiators to NumOut word-interleaved TCDM banks, with a
// round-robin arbiter per bank and a per-bank response pipeline matching bank read latency.
module tcdm_xbar_pipe #(
  parameter int unsigned NumIn        = 8,
  parameter int unsigned NumOut       = 16,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned WriteRespOn  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumIn-1:0]        req_i,
  input  logic [AddrWidth-1:0]    add_i   [NumIn],
  input  logic [NumIn-1:0]        wen_i,
  input  logic [DataWidth-1:0]    wdata_i [NumIn],
  input  logic [BeWidth-1:0]      be_i    [NumIn],
  output logic [NumIn-1:0]        gnt_o,
  output logic [NumIn-1:0]        vld_o,
  output logic [DataWidth-1:0]    rdata_o [NumIn],
  output logic [NumOut-1:0]       req_o,
  input  logic [NumOut-1:0]       gnt_i,
  output logic [AddrMemWidth-1:0] add_o   [NumOut],
  output logic [NumOut-1:0]       wen_o,
  output logic [DataWidth-1:0]    wdata_o [NumOut],
  output logic [BeWidth-1:0]      be_o    [NumOut],
  input  logic [DataWidth-1:0]    rdata_i [NumOut]
);

  localparam int unsigned BankSelW = $clog2(NumOut);
  localparam int unsigned ByteOff  = $clog2(DataWidth / 8);
  localparam int unsigned IdxW     = (NumIn > 1) ? $clog2(NumIn) : 1;

  if ((NumOut < 2) || ((NumOut & (NumOut - 1)) != 0)) begin : g_bad_numout
    $fatal(1, "NumOut must be a power of 2 and at least 2");
  end
  if ((MemLatency < 1) || (MemLatency > 8)) begin : g_bad_latency
    $fatal(1, "MemLatency must be in 1..8");
  end
  if ((ByteOff + BankSelW + AddrMemWidth) > AddrWidth) begin : g_bad_addr
    $fatal(1, "address fields exceed AddrWidth");
  end
  if (BeWidth != (DataWidth / 8)) begin : g_bad_be
    $fatal(1, "BeWidth must equal DataWidth/8");
  end

  logic [BankSelW-1:0]     bank_sel [NumIn];
  logic [AddrMemWidth-1:0] word_sel [NumIn];
  logic                    unused_addr;

  always_comb begin
    unused_addr = 1'b0;
    for (int m = 0; m < int'(NumIn); m++) begin
      bank_sel[m] = add_i[m][ByteOff +: BankSelW];
      word_sel[m] = add_i[m][ByteOff + BankSelW +: AddrMemWidth];
      unused_addr = unused_addr ^ (^add_i[m]);
    end
  end

  logic [IdxW-1:0]   rr_q   [NumOut];
  logic [IdxW-1:0]   rr_nxt [NumOut];
  logic [IdxW-1:0]   winner [NumOut];
  logic [NumOut-1:0] bank_req;

  // Scan candidates starting at the pointer, wrapping mod NumIn; first hit wins.
  always_comb begin
    int              cand;
    logic [IdxW-1:0] ci;
    cand = 0;
    ci   = '0;
    for (int k = 0; k < int'(NumOut); k++) begin
      bank_req[k] = 1'b0;
      winner[k]   = '0;
      for (int i = 0; i < int'(NumIn); i++) begin
        cand = int'(rr_q[k]) + i;
        if (cand >= int'(NumIn)) cand = cand - int'(NumIn);
        ci = IdxW'(cand);
        if (!bank_req[k] && req_i[ci] && (bank_sel[ci] == BankSelW'(k))) begin
          bank_req[k] = 1'b1;
          winner[k]   = ci;
        end
      end
      rr_nxt[k] = ((int'(winner[k]) + 1) >= int'(NumIn)) ? '0 : IdxW'(int'(winner[k]) + 1);
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NumOut); k++) begin
      req_o[k]   = bank_req[k];
      add_o[k]   = '0;
      wen_o[k]   = 1'b0;
      wdata_o[k] = '0;
      be_o[k]    = '0;
      if (bank_req[k]) begin
        add_o[k]   = word_sel[winner[k]];
        wen_o[k]   = wen_i[winner[k]];
        wdata_o[k] = wdata_i[winner[k]];
        be_o[k]    = be_i[winner[k]];
      end
    end
  end

  always_comb begin
    for (int m = 0; m < int'(NumIn); m++) begin
      gnt_o[m] = req_i[m] && bank_req[bank_sel[m]] &&
                 (winner[bank_sel[m]] == IdxW'(m)) && gnt_i[bank_sel[m]];
    end
  end

  logic            pipe_v_q   [NumOut][MemLatency];
  logic [IdxW-1:0] pipe_idx_q [NumOut][MemLatency];
  logic            pipe_wen_q [NumOut][MemLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(NumOut); k++) begin
        rr_q[k] <= '0;
        for (int s = 0; s < int'(MemLatency); s++) begin
          pipe_v_q[k][s]   <= 1'b0;
          pipe_idx_q[k][s] <= '0;
          pipe_wen_q[k][s] <= 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < int'(NumOut); k++) begin
        pipe_v_q[k][0]   <= bank_req[k] & gnt_i[k];
        pipe_idx_q[k][0] <= winner[k];
        pipe_wen_q[k][0] <= wen_o[k];
        for (int s = 1; s < int'(MemLatency); s++) begin
          pipe_v_q[k][s]   <= pipe_v_q[k][s-1];
          pipe_idx_q[k][s] <= pipe_idx_q[k][s-1];
          pipe_wen_q[k][s] <= pipe_wen_q[k][s-1];
        end
        // A stalled winner keeps its priority because the pointer only moves on acceptance.
        if (bank_req[k] && gnt_i[k]) rr_q[k] <= rr_nxt[k];
      end
    end
  end

  logic [NumIn-1:0] resp_dup;

  always_comb begin
    vld_o    = '0;
    resp_dup = '0;
    for (int m = 0; m < int'(NumIn); m++) rdata_o[m] = '0;
    for (int k = 0; k < int'(NumOut); k++) begin
      if (pipe_v_q[k][MemLatency-1] &&
          (!pipe_wen_q[k][MemLatency-1] || (WriteRespOn != 0))) begin
        if (vld_o[pipe_idx_q[k][MemLatency-1]]) resp_dup[pipe_idx_q[k][MemLatency-1]] = 1'b1;
        vld_o[pipe_idx_q[k][MemLatency-1]]   = 1'b1;
        rdata_o[pipe_idx_q[k][MemLatency-1]] = rdata_i[k];
      end
    end
  end

  // Uniform latency plus one grant per master per cycle means no master sees two banks at once.
  assert property (@(posedge clk_i) disable iff (!rst_ni) resp_dup == '0);

endmodule

// File: tb/tb_tcdm_xbar_pipe.sv
// Bench for tcdm_xbar_pipe: three instances (latency 2/3/4, write responses off/on/on)
// share one stimulus and are each compared every cycle against a behavioural model.
module tb_tcdm_xbar_pipe;
  localparam int NI = 4, NO = 8, AW = 32, DW = 32, BW = 4, AMW = 12, NC = 3;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [NI-1:0]  req_i, wen_i;
  logic [AW-1:0]  add_i   [NI];
  logic [DW-1:0]  wdata_i [NI];
  logic [BW-1:0]  be_i    [NI];
  logic [NO-1:0]  gnt_i;
  logic [DW-1:0]  rdata_i [NO];
  int checks = 0, errors = 0, tick = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_pat(input int k, input int t);
    return {16'(t), 8'(k), 8'hA5};
  endfunction
  function automatic logic [2:0] bank_of(input logic [AW-1:0] a);
    return 3'((a >> 2) % 8);
  endfunction
  function automatic logic [AMW-1:0] word_of(input logic [AW-1:0] a);
    return 12'((a >> 5) % 4096);
  endfunction

  task automatic chk(input string nm, input int cf, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d actual=%0h required=%0h at %0t", nm, cf, act, exp, $time);
    end
  endtask

  for (genvar c = 0; c < NC; c++) begin : g_cfg
    localparam int L  = 2 + c;
    localparam int WR = (c == 0) ? 0 : 1;
    logic [NI-1:0]  gnt_w, vld_w;
    logic [DW-1:0]  rdata_w [NI];
    logic [NO-1:0]  req_w, wen_w;
    logic [AMW-1:0] add_w   [NO];
    logic [DW-1:0]  wdata_w [NO];
    logic [BW-1:0]  be_w    [NO];

    tcdm_xbar_pipe #(
      .NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
      .AddrMemWidth(AMW), .MemLatency(L), .WriteRespOn(WR)
    ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_w), .vld_o(vld_w), .rdata_o(rdata_w),
      .req_o(req_w), .gnt_i(gnt_i), .add_o(add_w), .wen_o(wen_w), .wdata_o(wdata_w),
      .be_o(be_w), .rdata_i(rdata_i)
    );

    // Model: rr pointers plus a ring of responses keyed by the cycle they are due.
    int rr [NO];
    bit sv [8][NI];
    int sb [8][NI];
    bit sw [8][NI];
    int cyc = 0;

    always @(negedge clk) begin : model
      logic [1:0]     win [NO];
      bit             fnd [NO];
      logic [1:0]     mi;
      logic [2:0]     b, slot, slot_l;
      logic [NI-1:0]  eg, ev;
      logic [AMW-1:0] e_add;
      logic           e_wen;
      logic [DW-1:0]  e_wd;
      logic [BW-1:0]  e_be;
      if (!rst_ni) begin
        for (int k = 0; k < NO; k++) rr[k] = 0;
        for (int s = 0; s < 8; s++) for (int m = 0; m < NI; m++) sv[s][m] = 1'b0;
      end
      for (int k = 0; k < NO; k++) begin
        fnd[k] = 1'b0;
        win[k] = 2'd0;
        for (int i = 0; i < NI; i++) begin
          mi = 2'((rr[k] + i) % NI);
          if (!fnd[k] && req_i[mi] && (int'(bank_of(add_i[mi])) == k)) begin
            fnd[k] = 1'b1;
            win[k] = mi;
          end
        end
      end
      eg = '0;
      for (int m = 0; m < NI; m++) begin
        mi = 2'(m);
        b  = bank_of(add_i[mi]);
        eg[mi] = req_i[mi] && fnd[b] && (win[b] == mi) && gnt_i[b];
      end
      chk("gnt_o", c, 64'(gnt_w), 64'(eg));
      for (int k = 0; k < NO; k++) begin
        e_add = '0; e_wen = 1'b0; e_wd = '0; e_be = '0;
        if (fnd[k]) begin
          e_add = word_of(add_i[win[k]]);
          e_wen = wen_i[win[k]];
          e_wd  = wdata_i[win[k]];
          e_be  = be_i[win[k]];
        end
        chk("req_o", c, 64'(req_w[k]), 64'(fnd[k]));
        chk("add_o", c, 64'(add_w[k]), 64'(e_add));
        chk("wen_o", c, 64'(wen_w[k]), 64'(e_wen));
        chk("wdata_o", c, 64'(wdata_w[k]), 64'(e_wd));
        chk("be_o", c, 64'(be_w[k]), 64'(e_be));
      end
      slot = 3'(cyc % 8);
      ev = '0;
      for (int m = 0; m < NI; m++) ev[m] = sv[slot][m] && (!sw[slot][m] || (WR == 1));
      chk("vld_o", c, 64'(vld_w), 64'(ev));
      for (int m = 0; m < NI; m++) begin
        if (!ev[m]) chk("rdata_idle", c, 64'(rdata_w[m]), 64'(0));
        else if (!sw[slot][m]) chk("rdata_o", c, 64'(rdata_w[m]), 64'(rd_pat(sb[slot][m], tick)));
        sv[slot][m] = 1'b0;
      end
      if (rst_ni) begin
        for (int k = 0; k < NO; k++) begin
          if (fnd[k] && gnt_i[k]) begin
            slot_l = 3'((cyc + L) % 8);
            sv[slot_l][win[k]] = 1'b1;
            sb[slot_l][win[k]] = k;
            sw[slot_l][win[k]] = wen_i[win[k]];
            rr[k] = (int'(win[k]) + 1) % NI;
          end
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tick++;
    for (int k = 0; k < NO; k++) rdata_i[k] = rd_pat(k, tick);
  endtask

  task automatic idle();
    req_i = '0;
    wen_i = '0;
  endtask

  task automatic load(input int m, input int bank, input int word, input bit w, input logic [DW-1:0] d);
    logic [1:0] mi;
    mi = 2'(m);
    req_i[mi]   = 1'b1;
    add_i[mi]   = {15'(m * 5 + 3), 12'(word), 3'(bank), 2'(m)};
    wen_i[mi]   = w;
    wdata_i[mi] = d;
    be_i[mi]    = 4'hF;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_ni = 1'b1;
    req_i  = '0;
    wen_i  = '0;
    gnt_i  = '1;
    for (int m = 0; m < NI; m++) begin
      add_i[m] = '0; wdata_i[m] = '0; be_i[m] = '0;
    end
    for (int k = 0; k < NO; k++) rdata_i[k] = rd_pat(k, 0);
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_vld", 0, 64'({g_cfg[0].vld_w, g_cfg[1].vld_w, g_cfg[2].vld_w}), 64'(0));
    chk("rst_req", 0, 64'(g_cfg[0].req_w), 64'(0));

    // single load, address 0x24 -> bank 1 word 1
    step();
    req_i = 4'b0010; add_i[1] = 32'h24; wen_i = '0;
    @(negedge clk);
    chk("t1_gnt", 0, 64'(g_cfg[0].gnt_w), 64'(4'b0010));
    chk("t1_req", 0, 64'(g_cfg[0].req_w), 64'(8'b0000_0010));
    chk("t1_add", 0, 64'(g_cfg[0].add_w[1]), 64'(1));
    step(); idle();
    @(negedge clk);
    chk("t1_vld_early", 0, 64'(g_cfg[0].vld_w), 64'(0));
    step();
    @(negedge clk);
    chk("t1_vld", 0, 64'(g_cfg[0].vld_w), 64'(4'b0010));
    chk("t1_rdata", 0, 64'(g_cfg[0].rdata_w[1]), 64'(rd_pat(1, tick)));
    chk("t1_vld_l3_early", 1, 64'(g_cfg[1].vld_w), 64'(0));
    step();
    @(negedge clk);
    chk("t1_vld_l3", 1, 64'(g_cfg[1].vld_w), 64'(4'b0010));
    idle_cycles(4);

    // contention on bank 3: grants rotate 0,1,2,3,0
    for (int i = 0; i < 7; i++) begin
      step();
      if (i < 5) for (int m = 0; m < NI; m++) load(m, 3, i + m, 1'b0, '0);
      else idle();
      @(negedge clk);
      if (i < 5) chk("t2_gnt", 0, 64'(g_cfg[0].gnt_w), 64'(1 << (i % 4)));
      if (i >= 2) chk("t2_vld", 0, 64'(g_cfg[0].vld_w), 64'(1 << ((i - 2) % 4)));
    end
    idle_cycles(4);

    // backpressure: move bank 3 pointer to 2, then stall with masters 2 and 3
    step();
    load(1, 3, 7, 1'b0, '0);
    @(negedge clk);
    chk("t3_pre_gnt", 0, 64'(g_cfg[0].gnt_w), 64'(4'b0010));
    step(); idle();
    load(2, 3, 8, 1'b0, '0);
    load(3, 3, 9, 1'b0, '0);
    gnt_i[3] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) step();
      @(negedge clk);
      chk("t3_stall_gnt", 0, 64'(g_cfg[0].gnt_w), 64'(0));
      chk("t3_stall_req", 0, 64'(g_cfg[0].req_w[3]), 64'(1));
    end
    step();
    gnt_i[3] = 1'b1;
    @(negedge clk);
    chk("t3_resume_gnt", 0, 64'(g_cfg[0].gnt_w), 64'(4'b0100));
    step();
    req_i[2] = 1'b0;
    @(negedge clk);
    chk("t3_next_gnt", 0, 64'(g_cfg[0].gnt_w), 64'(4'b1000));
    idle_cycles(5);

    // store: response only where write responses are enabled
    step();
    load(0, 5, 9, 1'b1, 32'hCAFE_0001);
    be_i[0] = 4'b0011;
    @(negedge clk);
    chk("t4_gnt", 0, 64'(g_cfg[0].gnt_w), 64'(4'b0001));
    chk("t4_wen", 0, 64'(g_cfg[0].wen_w), 64'(8'h20));
    chk("t4_wdata", 0, 64'(g_cfg[0].wdata_w[5]), 64'(32'hCAFE_0001));
    chk("t4_be", 0, 64'(g_cfg[0].be_w[5]), 64'(4'b0011));
    chk("t4_add", 0, 64'(g_cfg[0].add_w[5]), 64'(9));
    for (int j = 1; j <= 4; j++) begin
      step();
      if (j == 1) idle();
      @(negedge clk);
      chk("t4_vld_wr_off", 0, 64'(g_cfg[0].vld_w), 64'(0));
      chk("t4_vld_wr_on", 1, 64'(g_cfg[1].vld_w), 64'((j == 3) ? 4'b0001 : 4'b0000));
    end
    idle_cycles(4);

    // four masters on four banks in one cycle
    step();
    for (int m = 0; m < NI; m++) load(m, m, m + 2, 1'b0, '0);
    @(negedge clk);
    chk("t5_gnt", 1, 64'(g_cfg[1].gnt_w), 64'(4'b1111));
    for (int j = 1; j <= 3; j++) begin
      step();
      if (j == 1) idle();
      @(negedge clk);
      chk("t5_vld", 1, 64'(g_cfg[1].vld_w), 64'((j == 3) ? 4'b1111 : 4'b0000));
    end
    idle_cycles(5);

    // reset one cycle after a grant drops the in-flight load and clears pointers
    step();
    load(2, 6, 4, 1'b0, '0);
    @(negedge clk);
    chk("t6_gnt", 2, 64'(g_cfg[2].gnt_w), 64'(4'b0100));
    step(); idle();
    rst_ni = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) step();
      if (j == 2) rst_ni = 1'b1;
      @(negedge clk);
      chk("t6_vld", 2, 64'(g_cfg[2].vld_w), 64'(0));
    end
    step();
    for (int m = 0; m < NI; m++) load(m, 6, m, 1'b0, '0);
    @(negedge clk);
    chk("t6_post_gnt", 2, 64'(g_cfg[2].gnt_w), 64'(4'b0001));
    idle_cycles(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tcdm_xbar_pipe.md
Name: tcdm_xbar_pipe

Overview:
- Parametrised full crossbar connecting NumIn initiator ports to NumOut word-interleaved TCDM banks.
- Each bank has its own round-robin arbiter whose pointer advances only on a grant.
- Each bank has a response-routing pipeline of configurable depth, so banks with MemLatency > 1 are supported; the older fixed-latency lic/bfly topologies do not support this.
- Sits between core/DMA ports and bank macros in the cluster. It is self-contained and instantiates no clos/bfly primitives.

Parameters:
- NumIn, 8, number of initiator ports, >= 1, any integer.
- NumOut, 16, number of banks, power of 2, >= 2.
- AddrWidth, 32, initiator address width.
- DataWidth, 32, data word width, power of 2, >= 8.
- BeWidth, DataWidth/8, byte-enable width.
- AddrMemWidth, 12, word-address bits per bank.
- MemLatency, 1, bank read latency in cycles, range 1..8.
- WriteRespOn, 1, 1 = stores also produce vld_o; 0 = only loads do.
- Derived, not overridable:
  - BankSelW = $clog2(NumOut)
  - ByteOff = $clog2(DataWidth/8)
  - IdxW = max(1,$clog2(NumIn))

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumIn  initiator request
- add_i  in  NumIn x AddrWidth  byte address
- wen_i  in  NumIn  1 = store, 0 = load
- wdata_i  in  NumIn x DataWidth  write data
- be_i  in  NumIn x BeWidth  byte enables
- gnt_o  out  NumIn  grant, combinational from req_i/add_i/gnt_i
- vld_o  out  NumIn  response valid
- rdata_o  out  NumIn x DataWidth  response data
- req_o  out  NumOut  bank request
- gnt_i  in  NumOut  bank ready
- add_o  out  NumOut x AddrMemWidth  bank word address
- wen_o  out  NumOut  bank store
- wdata_o  out  NumOut x DataWidth  bank write data
- be_o  out  NumOut x BeWidth  bank byte enables
- rdata_i  in  NumOut x DataWidth  bank read data, valid exactly MemLatency cycles after the accepting cycle

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous, active-low.
- Address decode:
  - bank = add_i[ByteOff +: BankSelW]
  - word = add_i[ByteOff+BankSelW +: AddrMemWidth]
  - Upper bits are ignored.
- Arbitration, per bank k:
  - Candidates are masters with req_i=1 targeting bank k.
  - Winner is the first candidate at or after rr_q[k], scanning upward and wrapping mod NumIn.
  - req_o[k] = any candidate.
  - add_o/wen_o/wdata_o/be_o[k] carry the winner's fields. They are '0 when req_o[k]=0.
  - gnt_o[m] = winner(bank(m))==m AND gnt_i[bank(m)].
- Pointer update:
  - On req_o[k]&gnt_i[k], rr_q[k] <= (winner+1) mod NumIn. Otherwise it holds.
  - A master held off by gnt_i=0 keeps priority (no pointer advance).
- Starvation bound: a continuously requesting master is granted within NumIn bank-accepted cycles.
- Response pipeline, per bank k (depth MemLatency):
  - Each entry holds {v, idx[IdxW], wen}.
  - Stage 0 is loaded with {req_o&gnt_i, winner, wen_o}; later stages shift every cycle.
  - Output stage L-1 with v=1 and (wen=0 OR WriteRespOn=1) drives vld_o[idx]=1 and rdata_o[idx]=rdata_i[k] in that same cycle, combinational from the stage register.
  - For writes, rdata_o carries rdata_i (don't-care). TB must not check it.
- Response uniqueness: a master is granted at most once per cycle and latency is uniform, so at most one bank returns to a given master per cycle. An assertion flags two or more.
- vld_o/rdata_o for an idle master: 0 / '0.
- Reset values: all rr_q=0 and all pipeline v=0.
  - vld_o=0 and rdata_o='0.
  - req_o, gnt_o and the bank data outputs are combinational, so they are 0 whenever req_i=0.
- Reset mid-operation: in-flight responses are dropped and no vld_o is produced for them. Initiators must reissue.
- Simultaneous events: a new grant and a pipeline output on the same bank in the same cycle are both serviced. Pipeline throughput is one access per bank per cycle.
- Elaboration assertions:
  - NumOut is a power of 2.
  - MemLatency is in 1..8.
  - ByteOff+BankSelW+AddrMemWidth <= AddrWidth.
  - BeWidth == DataWidth/8.

Test Plan:
- Single load: NumIn=4, NumOut=8, MemLatency=2. Master 1 loads addr 0x24 (bank 1, word 1), gnt_i=all 1.
  - Cycle 0: gnt_o=0010, req_o[1]=1, add_o[1]=1.
  - Cycle 2: vld_o=0010 and rdata_o[1]=rdata_i[1].
- Contention rotation: masters 0..3 continuously load bank 3.
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Each vld_o appears exactly MemLatency cycles after its grant.
- Backpressure hold: gnt_i[3]=0 for 3 cycles while masters 2 and 3 request bank 3 with rr_q=2.
  - No gnt_o during the stall.
  - When gnt_i[3] returns to 1, master 2 is granted first. rr_q never advanced during the stall.
- Write response: WriteRespOn=0, master 0 stores to bank 5 → gnt_o[0]=1, vld_o stays 0.
  - WriteRespOn=1, same stimulus → vld_o[0]=1 after MemLatency cycles.
- Parallel banks: 4 masters target banks 0,1,2,3 in the same cycle.
  - All four are granted in one cycle.
  - All four vld_o are asserted together at MemLatency=3.
- Reset in flight: assert rst_ni=0 one cycle after a grant with MemLatency=4.
  - vld_o stays 0 throughout.
  - After release the pipeline is empty and rr_q=0 (master 0 wins the first contention).
